// File: rtl/lut_table_loader.sv
// lut_table_loader: streams 2^N function samples in, keeps every 2^(N-P)-th
// sample (the anchors) and writes them into the coarse interpolation table.
// Optional macro LUT_ERRCHK_EN adds a checker that tracks the worst-case
// interpolation error against the discarded samples (err_max port).
module lut_table_loader #(
    parameter int unsigned DW = 8,
    parameter int unsigned N  = 8,
    parameter int unsigned P  = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic          lut_we,
    output logic [P-1:0]  lut_addr,
    output logic [DW-1:0] lut_wdata,
    output logic          busy,
    output logic          done
`ifdef LUT_ERRCHK_EN
    ,
    output logic [DW-1:0] err_max
`endif
);

    localparam int unsigned S = N - P;       // log2 of decimation factor
    localparam int unsigned D = 1 << S;      // decimation factor

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_FINAL = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  idx_q, idx_d;
    logic          we_q;
    logic [P-1:0]  addr_q;
    logic [DW-1:0] wdata_q;
    logic          accept;
    logic          anchor;

    assign s_ready   = (state_q == ST_LOAD);
    assign busy      = (state_q == ST_LOAD) || (state_q == ST_FINAL);
    assign done      = (state_q == ST_DONE);
    assign accept    = s_valid && s_ready;
    assign anchor    = (idx_q[S-1:0] == '0);
    assign lut_we    = we_q;
    assign lut_addr  = addr_q;
    assign lut_wdata = wdata_q;

    // Next-state and sample-index logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == '1) state_d = ST_FINAL;
                end
            end
            ST_FINAL: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM and index registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Registered coarse-table write port; addr/data hold between writes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= accept && anchor;
            if (accept && anchor) begin
                addr_q  <= idx_q[N-1:S];
                wdata_q <= s_data;
            end
        end
    end

`ifdef LUT_ERRCHK_EN
    logic [DW-1:0] anchor_q;
    logic [DW-1:0] a0_q;
    logic [DW-1:0] buf_q [1:D-1];
    logic [DW-1:0] err_q;
    logic [DW-1:0] y2;
    logic [DW-1:0] dy;
    logic [DW-1:0] kdy;
    logic [DW-1:0] ip;
    logic [DW-1:0] e;
    logic [DW-1:0] grp_err;

    assign err_max = err_q;

    // Worst error of the group opened by anchor_q; FINAL closes the wrap group
    always_comb begin
        y2      = (state_q == ST_FINAL) ? a0_q : s_data;
        dy      = y2 - anchor_q;
        kdy     = '0;
        ip      = '0;
        e       = '0;
        grp_err = '0;
        for (int unsigned k = 1; k < D; k++) begin
            kdy = dy * DW'(k);
            ip  = anchor_q + (kdy >> S);
            e   = (buf_q[k] >= ip) ? (buf_q[k] - ip) : (ip - buf_q[k]);
            if (e > grp_err) grp_err = e;
        end
    end

    // Sample buffers and running maximum error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            anchor_q <= '0;
            a0_q     <= '0;
            err_q    <= '0;
            for (int unsigned k = 1; k < D; k++) buf_q[k] <= '0;
        end else if ((state_q == ST_IDLE) && start) begin
            err_q <= '0;
        end else if (accept) begin
            if (anchor) begin
                anchor_q <= s_data;
                if (idx_q == '0) a0_q <= s_data;
                else if (grp_err > err_q) err_q <= grp_err;
            end else begin
                buf_q[idx_q[S-1:0]] <= s_data;
            end
        end else if (state_q == ST_FINAL) begin
            if (grp_err > err_q) err_q <= grp_err;
        end
    end
`endif

endmodule

// File: tb/tb_lut_table_loader.sv
// Self-checking bench for lut_table_loader: directed passes with a write
// scoreboard; err_max checks are compiled in when LUT_ERRCHK_EN is defined.
module tb_lut_table_loader;

    logic       clk = 1'b0;
    logic       rst_n, start, s_valid;
    logic [7:0] s_data;
    logic       s_ready, lut_we, busy, done;
    logic [5:0] lut_addr;
    logic [7:0] lut_wdata;
`ifdef LUT_ERRCHK_EN
    logic [7:0] err_max;
`endif

    int n_asserts = 0;
    int n_fail    = 0;
    int nwrites   = 0;
    logic [13:0] exp_q [$];
    logic [7:0]  data [256];

    lut_table_loader #(.DW(8), .N(8), .P(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .lut_we    (lut_we),
        .lut_addr  (lut_addr),
        .lut_wdata (lut_wdata),
        .busy      (busy),
        .done      (done)
`ifdef LUT_ERRCHK_EN
        ,
        .err_max   (err_max)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write scoreboard: every strobe must match the oldest expected anchor
    always @(negedge clk) begin
        if (lut_we === 1'b1) begin
            nwrites++;
            n_asserts++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_write observed=%0h expected=none", {lut_addr, lut_wdata});
            end
            if (exp_q.size() != 0) begin
                logic [13:0] ew;
                ew = exp_q.pop_front();
                n_asserts++;
                assert ({lut_addr, lut_wdata} === ew) else begin
                    n_fail++;
                    $error("FAIL write observed=%0h expected=%0h", {lut_addr, lut_wdata}, ew);
                end
            end
        end
    end

    function automatic logic [7:0] model_err();
        int worst = 0;
        for (int g = 0; g < 64; g++) begin
            int y1 = data[4*g];
            int y2 = data[(4*g + 4) % 256];
            int dy = (y2 - y1 + 256) % 256;
            for (int k = 1; k < 4; k++) begin
                int ip = (y1 + (((k * dy) % 256) >> 2)) % 256;
                int ev = int'(data[4*g + k]) - ip;
                if (ev < 0) ev = -ev;
                if (ev > worst) worst = ev;
            end
        end
        return 8'(worst);
    endfunction

    // bmode: 0 full rate, 1 toggle, 2 random; abort_at: reset after that idx
    task automatic run_pass(input int bmode, input int abort_at, input bit poke);
        int idx = 0;
        int cyc = 0;
        bit acc, anc;
        logic [7:0] exp_err;
        exp_err = model_err();
        nwrites = 0;
        @(negedge clk);
        start   = 1'b1;
        s_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("load_entry_ready", s_ready, 1);
        chk("load_entry_busy", busy, 1);
        while (idx < 256 && cyc < 2000) begin
            @(negedge clk);
            case (bmode)
                0:       s_valid = 1'b1;
                1:       s_valid = (cyc % 2 == 0);
                default: s_valid = 1'($urandom_range(0, 1));
            endcase
            start  = poke && (idx == 50);
            s_data = data[idx];
            acc = s_valid && s_ready;
            anc = acc && (idx % 4 == 0);
            if (anc) exp_q.push_back({6'(idx / 4), data[idx]});
            @(posedge clk); #1;
            start = 1'b0;
            chk("we_timing", lut_we, anc);
            if (acc) idx++;
            cyc++;
            if (abort_at >= 0 && idx == abort_at + 1) break;
        end
        chk("no_timeout", (cyc < 2000), 1);
        @(negedge clk);
        s_valid = 1'b0;
        if (abort_at >= 0) begin
            rst_n   = 1'b0;
            start   = 1'b1;
            s_valid = 1'b1;
            repeat (2) begin
                @(posedge clk); #1;
                chk("abort_we", lut_we, 0);
                chk("abort_done", done, 0);
                chk("abort_busy", busy, 0);
            end
            @(negedge clk);
            rst_n   = 1'b1;
            start   = 1'b0;
            s_valid = 1'b0;
            chk("abort_writes", nwrites, abort_at / 4 + 1);
            chk("abort_queue_empty", exp_q.size(), 0);
            chk("abort_last_addr", lut_addr, 0);
        end else begin
            chk("final_ready", s_ready, 0);
            chk("final_busy", busy, 1);
            chk("final_done", done, 0);
            @(posedge clk); #1;
            chk("done_pulse", done, 1);
            chk("done_busy", busy, 0);
`ifdef LUT_ERRCHK_EN
            chk("err_max", err_max, exp_err);
`endif
            start = poke;
            @(posedge clk); #1;
            start = 1'b0;
            chk("idle_done", done, 0);
            chk("idle_ready", s_ready, 0);
            chk("idle_busy", busy, 0);
            chk("write_count", nwrites, 64);
            chk("queue_empty", exp_q.size(), 0);
`ifdef LUT_ERRCHK_EN
            chk("err_hold", err_max, exp_err);
`endif
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h5a;
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_we", lut_we, 0);
            chk("rst_addr", lut_addr, 0);
            chk("rst_wdata", lut_wdata, 0);
            chk("rst_ready", s_ready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
`ifdef LUT_ERRCHK_EN
            chk("rst_err", err_max, 0);
`endif
        end
        @(negedge clk);
        rst_n   = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;

        for (int i = 0; i < 256; i++) data[i] = 8'(i);
        run_pass(0, -1, 1'b0);

        for (int i = 0; i < 256; i++) data[i] = 8'h80;
        run_pass(1, -1, 1'b0);

        for (int i = 0; i < 256; i++) data[i] = 8'h00;
        data[5] = 8'h30;
        run_pass(0, -1, 1'b0);

        data[5]   = 8'h00;
        data[254] = 8'h20;
        run_pass(0, -1, 1'b1);

        for (int i = 0; i < 256; i++) data[i] = 8'($urandom_range(0, 255));
        run_pass(2, 100, 1'b0);
        run_pass(2, -1, 1'b1);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
